// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: control FSM sequencing a shared multicycle RV32I datapath
module rv_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instret,
  output logic             fault,
  output logic [1:0]       fault_code
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, JALR = 4'd11, LUI = 4'd12, AUIPC = 4'd13, IDLE = 4'd14, FAULT = 4'd15
  } state_t;
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] LAST = WW'(WAIT_LIMIT - 1);
  state_t state, nxt;
  logic [WW-1:0] wait_cnt;
  logic [1:0] nxt_code;
  logic taken, bad_br, timeout, retire;
  assign state_dbg = state;
  assign bad_br = funct3[2:1] == 2'b01;
  // funct3[0] inverts the base condition selected by funct3[2:1]
  assign taken = funct3[0] ^ (funct3[2] ? (funct3[1] ? ltu : lt) : zero);
  // A ready in the last allowed wait cycle still completes the request
  assign timeout = mem_req && !mem_ready && wait_cnt == LAST;
  assign retire = nxt == FETCH && state inside {MEMWB, MEMWR, ALUWB, BRANCH, JAL, JALR};
  assign nxt_code = timeout ? 2'd3 : state == BRANCH ? 2'd2 : 2'd1;
  // Next-state selection
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:  nxt = timeout ? FAULT : mem_ready ? DECODE : FETCH;
      MEMRD:  nxt = timeout ? FAULT : mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = timeout ? FAULT : mem_ready ? FETCH : MEMWR;
      DECODE:
        case (opcode)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011: nxt = EXEC_R;
          7'b0010011: nxt = EXEC_I;
          7'b1100011: nxt = BRANCH;
          7'b1101111: nxt = JAL;
          7'b1100111: nxt = JALR;
          7'b0110111: nxt = LUI;
          7'b0010111: nxt = AUIPC;
          default:    nxt = FAULT;
        endcase
      MEMADR: nxt = opcode == 7'b0100011 ? MEMWR : MEMRD;
      EXEC_R, EXEC_I, LUI, AUIPC: nxt = ALUWB;
      MEMWB, ALUWB, JAL, JALR: nxt = FETCH;
      BRANCH: nxt = bad_br ? FAULT : FETCH;
      default: nxt = FAULT;
    endcase
  end
  // Datapath controls decoded from state; only FETCH strobes and branch pc_write look at inputs
  always_comb begin
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_sel = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op = 2'd0;
    reg_write = 1'b0;
    wb_sel = 2'd0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = 2'd2;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      MEMRD: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
      end
      MEMWB: begin
        reg_write = 1'b1;
        wb_sel = 2'd1;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 2'd2;
        alu_op = 2'd2;
      end
      EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_op = 2'd2;
      end
      LUI: begin
        alu_src_a = 2'd3;
        alu_src_b = 2'd1;
      end
      AUIPC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 2'd2;
        alu_op = 2'd1;
        pc_write = taken && !bad_br;
        pc_src = 2'd1;
      end
      JAL: begin
        reg_write = 1'b1;
        wb_sel = 2'd2;
        pc_write = 1'b1;
        pc_src = 2'd1;
      end
      JALR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        reg_write = 1'b1;
        wb_sel = 2'd2;
        pc_write = 1'b1;
        pc_src = 2'd2;
      end
      default: ;
    endcase
  end
  // State, retire counter, memory wait counter and sticky fault
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      instret <= '0;
      fault <= 1'b0;
      fault_code <= 2'd0;
    end else begin
      state <= nxt;
      wait_cnt <= mem_req && !mem_ready ? wait_cnt + 1'b1 : '0;
      if (retire)
        instret <= instret + 1'b1;
      if (nxt == FAULT && state != FAULT) begin
        fault <= 1'b1;
        fault_code <= nxt_code;
      end
    end
  end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: scoreboard bench for the multicycle control FSM
module tb_rv_multicycle_ctrl;
  localparam int WL = 16;
  localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  typedef struct {logic [6:0] op; logic [2:0] f3; logic z; logic l; logic lu; int fw; int dw;} instr_t;
  typedef struct {int cycles; int path; int rw; int wbs; int pcw; int pcs; int we; int irw; int code; int ret;} exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, fault;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, fault_code;
  logic [3:0] state_dbg;
  logic [31:0] instret;
  instr_t stim_q[$], prog[$], cur;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;

  rv_multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .state_dbg(state_dbg), .instret(instret), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  function automatic int add_st(input int p, input int s);
    return p * 16 + s + 1;
  endfunction

  function automatic bit br_taken(input instr_t i);
    case (i.f3)
      3'd0: return i.z;
      3'd1: return !i.z;
      3'd4: return i.l;
      3'd5: return !i.l;
      3'd6: return i.lu;
      3'd7: return !i.lu;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: per-instruction observable summary from the architectural rules
  function automatic exp_t model(input instr_t i, input int ret);
    exp_t e;
    e = '{default: 0};
    e.irw = 1;
    e.path = add_st(0, 0);
    if (i.fw >= WL) begin
      e.irw = 0;
      e.cycles = WL;
      e.code = 3;
      e.ret = ret;
      return e;
    end
    e.cycles = i.fw + 2;
    e.path = add_st(e.path, 1);
    case (i.op)
      OP_LD, OP_ST: begin
        e.path = add_st(add_st(e.path, 2), i.op == OP_LD ? 3 : 5);
        e.we = i.op == OP_ST ? (i.dw >= WL ? WL : i.dw + 1) : 0;
        if (i.dw >= WL) begin
          e.cycles += 1 + WL;
          e.code = 3;
        end else if (i.op == OP_LD) begin
          e.cycles += 3 + i.dw;
          e.path = add_st(e.path, 4);
          e.rw = 1;
          e.wbs = 1;
        end else e.cycles += 2 + i.dw;
      end
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin
        e.cycles += 2;
        e.path = add_st(add_st(e.path, i.op == OP_R ? 6 : i.op == OP_I ? 7 : i.op == OP_LUI ? 12 : 13), 8);
        e.rw = 1;
      end
      OP_BR: begin
        e.cycles += 1;
        e.path = add_st(e.path, 9);
        if (i.f3 inside {3'd2, 3'd3}) e.code = 2;
        else begin
          e.pcw = br_taken(i);
          e.pcs = e.pcw;
        end
      end
      OP_JAL, OP_JALR: begin
        e.cycles += 1;
        e.path = add_st(e.path, i.op == OP_JAL ? 10 : 11);
        e.rw = 1;
        e.wbs = 2;
        e.pcw = 1;
        e.pcs = i.op == OP_JAL ? 1 : 2;
      end
      default: e.code = 1;
    endcase
    e.ret = ret + (e.code == 0 ? 1 : 0);
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                input logic l, input logic lu, input int fw, input int dw);
    instr_t i;
    i.op = op; i.f3 = f3; i.z = z; i.l = l; i.lu = lu; i.fw = fw; i.dw = dw;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    int r;
    case ($urandom_range(0, 8))
      0: i.op = OP_LD;
      1: i.op = OP_ST;
      2: i.op = OP_R;
      3: i.op = OP_I;
      4: i.op = OP_BR;
      5: i.op = OP_JAL;
      6: i.op = OP_JALR;
      7: i.op = OP_LUI;
      default: i.op = OP_AUIPC;
    endcase
    r = $urandom_range(0, 5);
    i.f3 = 3'(r < 2 ? r : r + 2);
    i.z = 1'($urandom); i.l = 1'($urandom); i.lu = 1'($urandom);
    i.fw = $urandom_range(0, 7) == 0 ? WL - 1 : $urandom_range(0, 3);
    i.dw = $urandom_range(0, 7) == 0 ? WL - 1 : $urandom_range(0, 3);
    return i;
  endfunction

  function automatic instr_t rnd_fault();
    instr_t i;
    i = rnd_instr();
    case ($urandom_range(0, 3))
      0: begin
        i.op = 7'($urandom);
        while (i.op inside {OP_LD, OP_ST, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
          i.op = 7'($urandom);
      end
      1: begin
        i.op = OP_BR;
        i.f3 = {2'b01, 1'($urandom)};
      end
      2: i.fw = WL + $urandom_range(0, 3);
      default: begin
        i.op = $urandom_range(0, 1) ? OP_LD : OP_ST;
        i.dw = WL + $urandom_range(0, 3);
      end
    endcase
    return i;
  endfunction

  // Memory model: answers each request after its planned number of wait cycles
  initial begin : responder
    int pend, tgt;
    pend = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || !mem_req) begin
        mem_ready = 1'b0;
        pend = 0;
      end else begin
        tgt = mem_sel ? cur.dw : (stim_q.size() > 0 ? stim_q[0].fw : -1);
        mem_ready = pend == tgt;
        pend = mem_ready ? 0 : pend + 1;
        if (mem_ready && !mem_sel) begin
          cur = stim_q.pop_front();
          opcode = cur.op; funct3 = cur.f3; zero = cur.z; lt = cur.l; ltu = cur.lu;
        end
      end
    end
  end

  // Monitor: frames instructions by FETCH entry or fault and scores each against the queue
  initial begin : monitor
    int st, prev, cyc, path, rw, irw, we, wbs, pcw, pcs;
    bit active;
    exp_t e;
    prev = 14;
    active = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 0;
        prev = 14;
      end else begin
        st = int'(state_dbg);
        if (active && ((st == 0 && prev != 0) || (st == 15 && prev != 15))) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_record: state %0d reached with no expected record", st);
          end else begin
            e = exp_q.pop_front();
            chk("cycles", cyc, e.cycles);
            chk("state_path", path, e.path);
            chk("reg_write_cnt", rw, e.rw);
            chk("wb_sel", wbs, e.wbs);
            chk("pc_write_cnt", pcw, e.pcw);
            chk("pc_src", pcs, e.pcs);
            chk("mem_we_cnt", we, e.we);
            chk("ir_write_cnt", irw, e.irw);
            chk("fault_code", fault_code, e.code);
            chk("fault", fault, e.code != 0);
            chk("instret", instret, e.ret);
          end
          active = 0;
        end
        if (st == 0 && prev != 0) begin
          active = 1;
          cyc = 0; path = 0; rw = 0; irw = 0; we = 0; wbs = 0; pcw = 0; pcs = 0;
        end
        if (active && st != 15) begin
          cyc++;
          if (st != prev) path = add_st(path, st);
          rw += int'(reg_write);
          irw += int'(ir_write);
          we += int'(mem_req && mem_we);
          if (reg_write) wbs = int'(wb_sel);
          if (pc_write && !ir_write) begin
            pcw++;
            pcs = int'(pc_src);
          end
        end
        prev = st;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ctrl_zero", {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, alu_src_a,
        alu_src_b, alu_op, reg_write, wb_sel, fault, fault_code}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_state", state_dbg, 14);
    stim_q.delete();
    exp_q.delete();
    #17;
  endtask

  task automatic run_prog(input int abort_after);
    int ret, budget, q;
    bit flt;
    exp_t e;
    do_reset();
    ret = 0;
    flt = 0;
    foreach (prog[k])
      if (!flt) begin
        e = model(prog[k], ret);
        exp_q.push_back(e);
        ret = e.ret;
        flt = e.code != 0;
      end
    stim_q = prog;
    prog.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_state", state_dbg, 14);
    chk("idle_ctrl_zero", {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, alu_src_a,
        alu_src_b, alu_op, reg_write, wb_sel, fault, fault_code}, 0);
    @(negedge clk);
    chk("fetch_state", state_dbg, 0);
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_instret", instret, 0);
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      return;
    end
    budget = 3000;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: %0d records outstanding, expected 0", exp_q.size());
    end
    if (flt) begin
      q = 0;
      repeat (50) begin
        @(negedge clk);
        q += int'(mem_req);
      end
      chk("fault_quiet_mem_req", q, 0);
      chk("fault_sticky", fault, 1);
    end
  endtask

  initial begin : driver
    int n;
    prog.push_back(mk(OP_R, 3'd0, 0, 0, 0, 0, 0));
    run_prog(0);
    prog.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 0, 3));
    run_prog(0);
    prog.push_back(mk(OP_BR, 3'd0, 1, 0, 0, 0, 0));
    prog.push_back(mk(OP_BR, 3'd0, 0, 0, 0, 1, 0));
    prog.push_back(mk(OP_BR, 3'd6, 0, 0, 1, 0, 0));
    prog.push_back(mk(OP_BR, 3'd2, 1, 1, 1, 0, 0));
    run_prog(0);
    prog.push_back(mk(7'b0000000, 3'd0, 0, 0, 0, 0, 0));
    run_prog(0);
    prog.push_back(mk(OP_R, 3'd0, 0, 0, 0, WL, 0));
    run_prog(0);
    prog.push_back(mk(OP_R, 3'd0, 0, 0, 0, WL - 1, 0));
    prog.push_back(mk(OP_ST, 3'd2, 0, 0, 0, 0, WL - 1));
    prog.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 2, WL));
    run_prog(0);
    prog.push_back(mk(OP_JAL, 3'd0, 0, 0, 0, 1, 0));
    prog.push_back(mk(OP_JALR, 3'd0, 0, 0, 0, 0, 0));
    prog.push_back(mk(OP_LUI, 3'd0, 0, 0, 0, 2, 0));
    prog.push_back(mk(OP_AUIPC, 3'd0, 0, 0, 0, 0, 0));
    prog.push_back(mk(OP_I, 3'd0, 0, 0, 0, 0, 0));
    prog.push_back(mk(OP_ST, 3'd2, 0, 0, 0, 0, 0));
    run_prog(0);
    prog.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 0, 5));
    prog.push_back(mk(OP_R, 3'd0, 0, 0, 0, 0, 0));
    run_prog(5);
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(3, 8);
      for (int k = 0; k < n; k++) prog.push_back(rnd_instr());
      if ($urandom_range(0, 2) == 0) prog.push_back(rnd_fault());
      run_prog(0);
    end
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
